// File: rtl/rgbw_frame_transmitter_pkg.sv
// -----------------------------------------------------------------------------
// rgbw_frame_transmitter_pkg
//   Shared definitions for the RGBW control-frame SPI transmitter: frame length,
//   default header byte, byte positions inside the frame and the sequencer
//   state encoding.
// -----------------------------------------------------------------------------
package rgbw_frame_transmitter_pkg;

    localparam int         FRAME_LEN         = 8;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

    // Position of each field in the transmitted byte sequence.
    localparam int IDX_SYNC = 0;
    localparam int IDX_LINT = 1;
    localparam int IDX_CIDX = 2;
    localparam int IDX_R    = 3;
    localparam int IDX_G    = 4;
    localparam int IDX_B    = 5;
    localparam int IDX_W    = 6;
    localparam int IDX_MODE = 7;

    typedef logic [FRAME_LEN-1:0][7:0] frame_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_GAP      = 3'd3,
        ST_CS_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } tx_state_e;

endpackage

// File: rtl/rgbw_frame_transmitter_spi_byte_shifter.sv
// -----------------------------------------------------------------------------
// rgbw_frame_transmitter_spi_byte_shifter
//   Shifts one byte out MSB first in SPI mode 0. Each bit spends CLK_DIV clk
//   cycles with sclk low followed by CLK_DIV cycles with sclk high; mosi only
//   moves on the sclk falling edge.
//
//   clk          in   system clock
//   reset        in   synchronous, active-low
//   load         in   capture load_data; mosi shows its bit 7 next cycle,
//                     sclk forced low, shifter parked until shift_start
//   load_data    in   byte to transmit
//   shift_start  in   begin clocking the loaded byte (first low half-period
//                     starts next cycle)
//   sclk         out  SPI clock, idle low (registered)
//   mosi         out  SPI data (registered)
//   byte_done    out  high during the final cycle of the byte; sclk falls
//                     for the last time on the following edge
// -----------------------------------------------------------------------------
module rgbw_frame_transmitter_spi_byte_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       shift_start,
    output logic       sclk,
    output logic       mosi,
    output logic       byte_done
);

    localparam int             DIV_W    = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [7:0]       shreg_q;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_idx_q;
    logic             active_q;
    logic             sclk_q;
    logic             half_end;

    assign half_end  = (div_q == DIV_LAST);
    // Lets the sequencer load the next byte on the very edge where sclk falls,
    // so the gap already shows the new bit 7.
    assign byte_done = active_q && sclk_q && half_end && (bit_idx_q == 3'd0);

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg_q   <= '0;
            div_q     <= '0;
            bit_idx_q <= '0;
            active_q  <= 1'b0;
            sclk_q    <= 1'b0;
        end else if (load) begin
            shreg_q   <= load_data;
            div_q     <= '0;
            bit_idx_q <= 3'd7;
            active_q  <= 1'b0;
            sclk_q    <= 1'b0;
        end else if (shift_start) begin
            active_q  <= 1'b1;
            div_q     <= '0;
        end else if (active_q) begin
            if (!half_end) begin
                div_q <= div_q + 1'b1;
            end else begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
                if (sclk_q) begin
                    // Falling edge: advance to the next bit, or stop after bit 0
                    // leaving mosi on the last bit.
                    if (bit_idx_q == 3'd0) begin
                        active_q <= 1'b0;
                    end else begin
                        bit_idx_q <= bit_idx_q - 3'd1;
                        shreg_q   <= {shreg_q[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign sclk = sclk_q;
    assign mosi = shreg_q[7];

endmodule

// File: rtl/rgbw_frame_transmitter.sv
// -----------------------------------------------------------------------------
// rgbw_frame_transmitter
//   SPI master that sends the 8-byte RGBW control frame
//   SYNC_BYTE, lint, color_idx, red, green, blue, white, mode
//   inside a single cs_n assertion. Inputs are snapshotted when start is
//   accepted in IDLE; start while busy is ignored.
//
//   clk           in   system clock
//   reset         in   synchronous, active-low
//   start         in   request one frame (sampled only when idle)
//   lint_in ..
//   mode_in       in   the seven payload bytes
//   busy          out  high from the cycle after an accepted start through
//                      the done cycle
//   done          out  one-cycle pulse at frame end (cs_n already high)
//   sclk          out  SPI clock, idle low
//   mosi          out  SPI data, MSB first
//   cs_n          out  chip select, active low
// -----------------------------------------------------------------------------
module rgbw_frame_transmitter
    import rgbw_frame_transmitter_pkg::*;
#(
    parameter int         CLK_DIV   = 4,
    parameter int         GAP_SCLK  = 1,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] lint_in,
    input  logic [7:0] color_idx_in,
    input  logic [7:0] red_in,
    input  logic [7:0] green_in,
    input  logic [7:0] blue_in,
    input  logic [7:0] white_in,
    input  logic [7:0] mode_in,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n
);

    localparam int             CNT_W      = $clog2(2 * CLK_DIV * GAP_SCLK) + 1;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(2 * CLK_DIV * GAP_SCLK - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    frame_t           frame_q;

    logic             capture;
    logic             sh_load;
    logic [7:0]       sh_load_data;
    logic             sh_start;
    logic             sh_done;

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        byte_idx_d   = byte_idx_q;
        cs_n_d       = cs_n_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        capture      = 1'b0;
        sh_load      = 1'b0;
        sh_load_data = '0;
        sh_start     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // The header is loaded straight into the shifter so mosi
                    // carries its bit 7 in the first cs_n-low cycle.
                    capture      = 1'b1;
                    sh_load      = 1'b1;
                    sh_load_data = SYNC_BYTE;
                    cs_n_d       = 1'b0;
                    busy_d       = 1'b1;
                    cnt_d        = '0;
                    byte_idx_d   = 3'd0;
                    state_d      = ST_CS_SETUP;
                end
            end
            ST_CS_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    sh_start = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (sh_done) begin
                    cnt_d = '0;
                    if (byte_idx_q == 3'(IDX_MODE)) begin
                        state_d = ST_CS_HOLD;
                    end else begin
                        byte_idx_d   = byte_idx_q + 3'd1;
                        sh_load      = 1'b1;
                        sh_load_data = frame_q[byte_idx_q + 3'd1];
                        state_d      = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    sh_start = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CS_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            byte_idx_q <= '0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            byte_idx_q <= byte_idx_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the frame snapshot has no reset; it is always written on an
    // accepted start before any byte of it is read.
    always_ff @(posedge clk) begin
        if (capture) begin
            frame_q[IDX_SYNC] <= SYNC_BYTE;
            frame_q[IDX_LINT] <= lint_in;
            frame_q[IDX_CIDX] <= color_idx_in;
            frame_q[IDX_R]    <= red_in;
            frame_q[IDX_G]    <= green_in;
            frame_q[IDX_B]    <= blue_in;
            frame_q[IDX_W]    <= white_in;
            frame_q[IDX_MODE] <= mode_in;
        end
    end

    rgbw_frame_transmitter_spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (sh_load),
        .load_data   (sh_load_data),
        .shift_start (sh_start),
        .sclk        (sclk),
        .mosi        (mosi),
        .byte_done   (sh_done)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign cs_n = cs_n_q;

endmodule

// File: tb/tb_rgbw_frame_transmitter.sv
// -----------------------------------------------------------------------------
// tb_rgbw_frame_transmitter
//   Two transmitters share all inputs: d0 with CLK_DIV=2 and d1 with CLK_DIV=1,
//   both GAP_SCLK=1. A frame-level model predicts every output in every cycle
//   from the frame timing rules; a byte monitor decodes mosi at sclk rises;
//   directed steps compare decoded bytes and frame times against literals.
// -----------------------------------------------------------------------------
module tb_rgbw_frame_transmitter;

    localparam int GAP = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] lint_in = '0, color_idx_in = '0, red_in = '0, green_in = '0;
    logic [7:0] blue_in = '0, white_in = '0, mode_in = '0;

    logic sclk_w [2];
    logic mosi_w [2];
    logic cs_n_w [2];
    logic busy_w [2];
    logic done_w [2];

    int n_cmp = 0;
    int n_err = 0;

    rgbw_frame_transmitter #(.CLK_DIV(2), .GAP_SCLK(GAP), .SYNC_BYTE(8'h55)) dut (
        .clk(clk), .reset(reset), .start(start),
        .lint_in(lint_in), .color_idx_in(color_idx_in), .red_in(red_in),
        .green_in(green_in), .blue_in(blue_in), .white_in(white_in), .mode_in(mode_in),
        .busy(busy_w[0]), .done(done_w[0]), .sclk(sclk_w[0]), .mosi(mosi_w[0]), .cs_n(cs_n_w[0])
    );

    rgbw_frame_transmitter #(.CLK_DIV(1), .GAP_SCLK(GAP), .SYNC_BYTE(8'h55)) dut_fast (
        .clk(clk), .reset(reset), .start(start),
        .lint_in(lint_in), .color_idx_in(color_idx_in), .red_in(red_in),
        .green_in(green_in), .blue_in(blue_in), .white_in(white_in), .mode_in(mode_in),
        .busy(busy_w[1]), .done(done_w[1]), .sclk(sclk_w[1]), .mosi(mosi_w[1]), .cs_n(cs_n_w[1])
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int k_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int k);
        return k * (2 + 128 + 14 * GAP);
    endfunction

    // Expected outputs c cycles after cs_n fell, derived from the frame layout:
    // setup K, 8 bytes of 16K with 2K*GAP gaps between them, hold K, then done.
    function automatic void exp_out(input int c, input int k, input logic [63:0] fr,
                                    output logic e_cs_n, output logic e_sclk,
                                    output logic e_mosi, output logic e_mosi_v,
                                    output logic e_done);
        int r, p, bi, q, bpos;
        e_cs_n = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0; e_mosi_v = 1'b0; e_done = 1'b0;
        if (c == frame_len(k)) begin
            e_cs_n = 1'b1;
            e_done = 1'b1;
        end else if (c < k) begin
            e_mosi = fr[63]; e_mosi_v = 1'b1;
        end else begin
            r = c - k;
            p = 16 * k + 2 * k * GAP;
            if (r < 7 * p) begin bi = r / p; q = r % p; end
            else begin bi = 7; q = r - 7 * p; end
            if (q < 16 * k) begin
                bpos   = q / (2 * k);
                e_sclk = ((q % (2 * k)) >= k);
                e_mosi = fr[63 - 8 * bi - bpos];
                e_mosi_v = 1'b1;
            end else if (bi < 7) begin
                e_mosi = fr[63 - 8 * (bi + 1)];
                e_mosi_v = 1'b1;
            end
        end
    endfunction

    // ---------------- frame-level model, advanced on posedge ----------------
    bit          mdl_valid = 1'b0;
    bit          mdl_active [2];
    int          mdl_c [2];
    logic [63:0] mdl_frame [2];
    bit          mdl_mosi_zero [2];
    int          cycle = 0;

    always @(posedge clk) begin
        cycle++;
        for (int d = 0; d < 2; d++) begin
            if (!reset) begin
                mdl_valid = 1'b1;
                mdl_active[d] = 1'b0;
                mdl_mosi_zero[d] = 1'b1;
            end else if (mdl_active[d]) begin
                if (mdl_c[d] == frame_len(k_of(d))) mdl_active[d] = 1'b0;
                else mdl_c[d]++;
            end else if (start) begin
                mdl_active[d] = 1'b1;
                mdl_c[d] = 0;
                mdl_mosi_zero[d] = 1'b0;
                mdl_frame[d] = {8'h55, lint_in, color_idx_in, red_in, green_in,
                                blue_in, white_in, mode_in};
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic e_cs_n, e_sclk, e_mosi, e_mosi_v, e_done;
        if (mdl_valid) begin
            for (int d = 0; d < 2; d++) begin
                if (mdl_active[d]) begin
                    exp_out(mdl_c[d], k_of(d), mdl_frame[d], e_cs_n, e_sclk, e_mosi, e_mosi_v, e_done);
                    check($sformatf("d%0d.cs_n c=%0d", d, mdl_c[d]), cs_n_w[d], e_cs_n);
                    check($sformatf("d%0d.sclk c=%0d", d, mdl_c[d]), sclk_w[d], e_sclk);
                    check($sformatf("d%0d.busy c=%0d", d, mdl_c[d]), busy_w[d], 1);
                    check($sformatf("d%0d.done c=%0d", d, mdl_c[d]), done_w[d], e_done);
                    if (e_mosi_v) check($sformatf("d%0d.mosi c=%0d", d, mdl_c[d]), mosi_w[d], e_mosi);
                end else begin
                    check($sformatf("d%0d.idle_cs_n", d), cs_n_w[d], 1);
                    check($sformatf("d%0d.idle_sclk", d), sclk_w[d], 0);
                    check($sformatf("d%0d.idle_busy", d), busy_w[d], 0);
                    check($sformatf("d%0d.idle_done", d), done_w[d], 0);
                    if (mdl_mosi_zero[d]) check($sformatf("d%0d.idle_mosi", d), mosi_w[d], 0);
                end
            end
        end
    end

    // ---------------- byte monitor and frame timing ----------------
    logic [7:0] rx_q0 [$];
    logic [7:0] rx_q1 [$];
    logic [7:0] mon_sh [2];
    int         mon_bits [2];
    logic       sclk_prev [2];
    logic       cs_prev [2];
    int         t_fall [2];
    int         frame_time [2];
    int         done_cnt [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            mon_bits[d] = 0; sclk_prev[d] = 1'b0; cs_prev[d] = 1'b1;
            t_fall[d] = 0; frame_time[d] = 0; done_cnt[d] = 0; mon_sh[d] = '0;
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cs_n_w[d] === 1'b1) begin
                mon_bits[d] = 0;
            end else if (sclk_w[d] === 1'b1 && sclk_prev[d] === 1'b0) begin
                mon_sh[d] = {mon_sh[d][6:0], mosi_w[d]};
                mon_bits[d]++;
                if (mon_bits[d] == 8) begin
                    if (d == 0) rx_q0.push_back(mon_sh[d]);
                    else rx_q1.push_back(mon_sh[d]);
                    mon_bits[d] = 0;
                end
            end
            if (cs_n_w[d] === 1'b0 && cs_prev[d] === 1'b1) t_fall[d] = cycle;
            if (done_w[d] === 1'b1) begin
                done_cnt[d]++;
                frame_time[d] = cycle - t_fall[d];
            end
            sclk_prev[d] = sclk_w[d];
            cs_prev[d] = cs_n_w[d];
        end
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic set_inputs(input logic [55:0] v);
        lint_in = v[55:48]; color_idx_in = v[47:40]; red_in = v[39:32];
        green_in = v[31:24]; blue_in = v[23:16]; white_in = v[15:8]; mode_in = v[7:0];
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic clear_rx();
        rx_q0.delete();
        rx_q1.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy_w[0] !== 1'b0 || busy_w[1] !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, ".timeout"}, (n >= budget), 0);
        #1;
    endtask

    task automatic check_frame(input string name, input int d, input logic [63:0] exp);
        logic [7:0] got [$];
        if (d == 0) got = rx_q0; else got = rx_q1;
        check({name, ".nbytes"}, got.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < got.size()) check($sformatf("%s.byte%0d", name, i), got[i], exp[63 - 8 * i -: 8]);
    endtask

    task automatic check_reset_outputs(input string name, input int d);
        check({name, ".cs_n"}, cs_n_w[d], 1);
        check({name, ".sclk"}, sclk_w[d], 0);
        check({name, ".mosi"}, mosi_w[d], 0);
        check({name, ".busy"}, busy_w[d], 0);
        check({name, ".done"}, done_w[d], 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int d0, d1;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst.d0", 0);
        check_reset_outputs("rst.d1", 1);

        // 1: basic frame, both dividers
        clear_rx();
        d0 = done_cnt[0]; d1 = done_cnt[1];
        set_inputs(56'h80_03_FF_00_A5_5A_02);
        pulse_start();
        wait_idle("t1", 1000);
        check_frame("t1.d0", 0, 64'h55_80_03_FF_00_A5_5A_02);
        check_frame("t1.d1", 1, 64'h55_80_03_FF_00_A5_5A_02);
        check("t1.time_d0", frame_time[0], 288);
        check("t1.time_d1", frame_time[1], 144);
        check("t1.dones_d0", done_cnt[0] - d0, 1);
        check("t1.dones_d1", done_cnt[1] - d1, 1);

        // 2: start re-asserted while busy is ignored
        clear_rx();
        d0 = done_cnt[0]; d1 = done_cnt[1];
        set_inputs(56'h12_34_56_78_9A_BC_DE);
        pulse_start();
        repeat (48) @(negedge clk);
        set_inputs(56'hFF_FF_FF_FF_FF_FF_FF);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_idle("t2", 1000);
        check_frame("t2.d0", 0, 64'h55_12_34_56_78_9A_BC_DE);
        check_frame("t2.d1", 1, 64'h55_12_34_56_78_9A_BC_DE);
        check("t2.dones_d0", done_cnt[0] - d0, 1);
        check("t2.dones_d1", done_cnt[1] - d1, 1);

        // 3: start held high for 700 cycles gives back-to-back frames
        d0 = done_cnt[0]; d1 = done_cnt[1];
        set_inputs(56'h01_02_04_08_10_20_40);
        @(negedge clk) start = 1'b1;
        repeat (700) @(negedge clk);
        #1;
        check("t3.window_dones_d0", done_cnt[0] - d0, 2);
        check("t3.window_dones_d1", done_cnt[1] - d1, 4);
        start = 1'b0;
        wait_idle("t3", 1000);
        check("t3.total_dones_d0", done_cnt[0] - d0, 3);
        check("t3.total_dones_d1", done_cnt[1] - d1, 5);

        // 4: reset in byte 3 bit 4 of the CLK_DIV=2 frame, then a clean frame
        clear_rx();
        d0 = done_cnt[0]; d1 = done_cnt[1];
        set_inputs(56'hC3_3C_E7_7E_0F_F0_99);
        pulse_start();
        repeat (122) @(negedge clk);
        check("t4.d0_busy_before_reset", busy_w[0], 1);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("t4.d0", 0);
        check_reset_outputs("t4.d1", 1);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("t4.no_done_d0", done_cnt[0] - d0, 0);
        check("t4.no_done_d1", done_cnt[1] - d1, 0);
        clear_rx();
        set_inputs(56'h0F_1E_2D_3C_4B_5A_69);
        pulse_start();
        wait_idle("t4", 1000);
        check_frame("t4.d0", 0, 64'h55_0F_1E_2D_3C_4B_5A_69);
        check_frame("t4.d1", 1, 64'h55_0F_1E_2D_3C_4B_5A_69);

        // 5: inputs change right after capture
        clear_rx();
        set_inputs(56'hDE_AD_BE_EF_01_23_45);
        @(negedge clk) start = 1'b1;
        @(negedge clk) begin
            start = 1'b0;
            set_inputs(56'h11_22_33_44_55_66_77);
        end
        wait_idle("t5", 1000);
        check_frame("t5.d0", 0, 64'h55_DE_AD_BE_EF_01_23_45);
        check_frame("t5.d1", 1, 64'h55_DE_AD_BE_EF_01_23_45);

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
